// File: rtl/hid_key_events.sv
// Keyboard report differ: turns report-to-report changes into press/release events, 16-cycle scan per report.
// Events are queued in a FIFO with valid/ready; on a full FIFO they are dropped and overflow is flagged.
module hid_key_events #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] usb_type,
    input  logic       usb_report,
    input  logic [7:0] key_modifiers,
    input  logic [7:0] key1,
    input  logic [7:0] key2,
    input  logic [7:0] key3,
    input  logic [7:0] key4,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic       ev_press,
    output logic [7:0] ev_code,
    output logic       busy,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN_MOD, SCAN_REL, SCAN_PRS} state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      new_mod_q, new_mod_d, prev_mod_q, prev_mod_d;
    logic [3:0][7:0] new_keys_q, new_keys_d, prev_keys_q, prev_keys_d;
    logic            busy_q, busy_d, overflow_q, overflow_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [8:0]      fifo_mem [FIFO_DEPTH];

    logic [3:0][7:0] in_keys;
    logic            rollover, prev_nonzero;
    logic            cand_vld, cand_press;
    logic [7:0]      cand_code, slot_code;
    logic [3:0][7:0] scan_keys, other_keys;
    logic            seen;
    logic            push, pop;

    assign in_keys = {key4, key3, key2, key1};

    // Candidate for the current scan step; a slot is skipped if its code is in
    // the other report or already appeared in an earlier slot of this report.
    always_comb begin
        cand_vld   = 1'b0;
        cand_press = 1'b0;
        cand_code  = 8'h00;
        scan_keys  = prev_keys_q;
        other_keys = new_keys_q;
        if (state_q == SCAN_PRS) begin
            scan_keys  = new_keys_q;
            other_keys = prev_keys_q;
        end
        slot_code = scan_keys[idx_q[1:0]];
        seen = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (other_keys[j] == slot_code) seen = 1'b1;
            if (j < int'(idx_q[1:0]) && scan_keys[j] == slot_code) seen = 1'b1;
        end
        case (state_q)
            SCAN_MOD: begin
                if (new_mod_q[idx_q] != prev_mod_q[idx_q]) begin
                    cand_vld   = 1'b1;
                    cand_press = new_mod_q[idx_q];
                    cand_code  = {5'b11100, idx_q};
                end
            end
            SCAN_REL, SCAN_PRS: begin
                if (slot_code != 8'h00 && !seen) begin
                    cand_vld   = 1'b1;
                    cand_press = (state_q == SCAN_PRS);
                    cand_code  = slot_code;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        new_mod_d    = new_mod_q;
        new_keys_d   = new_keys_q;
        prev_mod_d   = prev_mod_q;
        prev_keys_d  = prev_keys_q;
        busy_d       = busy_q;
        rollover     = 1'b0;
        for (int j = 0; j < 4; j++) begin
            if (in_keys[j] == 8'h01) rollover = 1'b1;
        end
        prev_nonzero = (prev_mod_q != 8'h00) || (prev_keys_q != '0);
        case (state_q)
            IDLE: begin
                if (usb_report && usb_type == 2'd1) begin
                    if (!rollover) begin
                        new_mod_d  = key_modifiers;
                        new_keys_d = in_keys;
                        state_d    = SCAN_MOD;
                        idx_d      = 3'd0;
                        busy_d     = 1'b1;
                    end
                end else if (usb_type != 2'd1 && prev_nonzero) begin
                    // Keyboard gone: scan an empty report to release everything held.
                    new_mod_d  = 8'h00;
                    new_keys_d = '0;
                    state_d    = SCAN_MOD;
                    idx_d      = 3'd0;
                    busy_d     = 1'b1;
                end
            end
            SCAN_MOD: begin
                if (idx_q == 3'd7) begin
                    state_d = SCAN_REL;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            SCAN_REL: begin
                if (idx_q == 3'd3) begin
                    state_d = SCAN_PRS;
                    idx_d   = 3'd0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            SCAN_PRS: begin
                if (idx_q == 3'd3) begin
                    state_d     = IDLE;
                    idx_d       = 3'd0;
                    prev_mod_d  = new_mod_q;
                    prev_keys_d = new_keys_q;
                    busy_d      = 1'b0;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign ev_valid = (count_q != '0);
    assign pop      = ev_valid && ev_ready;
    assign push     = cand_vld && ((count_q < DEPTH_C) || pop);

    always_comb begin
        wr_ptr_d   = wr_ptr_q + AW'(push);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = overflow_q | (cand_vld & ~push);
    end

    assign {ev_press, ev_code} = ev_valid ? fifo_mem[rd_ptr_q] : 9'd0;
    assign busy     = busy_q;
    assign overflow = overflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= 3'd0;
            new_mod_q   <= 8'h00;
            new_keys_q  <= '0;
            prev_mod_q  <= 8'h00;
            prev_keys_q <= '0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            new_mod_q   <= new_mod_d;
            new_keys_q  <= new_keys_d;
            prev_mod_q  <= prev_mod_d;
            prev_keys_q <= prev_keys_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_q] <= {cand_press, cand_code};
    end

endmodule
